// File: rtl/key_extract_pkg.sv
// Shared widths, FSM encoding and lookup-miss defaults for the key extract scheduler.
package key_extract_pkg;

  localparam int WIDTH_2B = 16;
  localparam int WIDTH_4B = 32;
  localparam int WIDTH_6B = 48;

  localparam int PHV_LEN_DEF  = 64*WIDTH_6B + 64*WIDTH_4B + 64*WIDTH_2B + 256;
  localparam int KEY_LEN_DEF  = 32*WIDTH_6B + 32*WIDTH_4B + 32*WIDTH_2B + 1;
  localparam int KEY_OFF_DEF  = 32*6*3 + 20;
  localparam int VLANID_W_DEF = 12;
  localparam int IDX_W_DEF    = 4;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_LOOKUP = 4'b0010,
    ST_ISSUE  = 4'b0100,
    ST_GAP    = 4'b1000
  } state_e;

  // A miss yields offset 0 and an all-ones mask, so the key is 0 except bit 0.
  localparam logic MISS_OFFSET_BIT = 1'b0;
  localparam logic MISS_MASK_BIT   = 1'b1;

endpackage

// File: rtl/key_cfg_table.sv
// Per-VLAN {valid, offset, mask} table: one write port with clear, one registered read port.
module key_cfg_table
  import key_extract_pkg::*;
#(
  parameter int KEY_OFF = KEY_OFF_DEF,
  parameter int KEY_LEN = KEY_LEN_DEF,
  parameter int IDX_W   = IDX_W_DEF
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic               wr_clr,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [KEY_OFF-1:0] wr_offset,
  input  logic [KEY_LEN-1:0] wr_mask,
  input  logic               rd_en,
  input  logic [IDX_W-1:0]   rd_addr,
  output logic               rd_valid,
  output logic [KEY_OFF-1:0] rd_offset,
  output logic [KEY_LEN-1:0] rd_mask
);

  localparam int DEPTH = 2**IDX_W;

  logic [DEPTH-1:0]   valid_r;
  logic [KEY_OFF-1:0] offset_mem_r [DEPTH];
  logic [KEY_LEN-1:0] mask_mem_r   [DEPTH];

  // Valid bits: the only table state cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_addr] <= ~wr_clr;
    end
  end

  // Entry data: a clear leaves the stored words untouched.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_clr) begin
      offset_mem_r[wr_addr] <= wr_offset;
      mask_mem_r[wr_addr]   <= wr_mask;
    end
  end

  // Read valid: sampled before any same-edge write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
    end else if (rd_en) begin
      rd_valid <= valid_r[rd_addr];
    end
  end

  // Read data, held between lookups.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_offset <= offset_mem_r[rd_addr];
      rd_mask   <= mask_mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/key_extract_sched.sv
// Paces PHVs into the key extractor (4-cycle slots) and attaches the per-VLAN offset/mask.
module key_extract_sched
  import key_extract_pkg::*;
#(
  parameter int PHV_LEN        = PHV_LEN_DEF,
  parameter int KEY_LEN        = KEY_LEN_DEF,
  parameter int KEY_OFF        = KEY_OFF_DEF,
  parameter int C_VLANID_WIDTH = VLANID_W_DEF,
  parameter int IDX_W          = IDX_W_DEF
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PHV_LEN-1:0]        phv_in,
  input  logic [C_VLANID_WIDTH-1:0] vlan_id_in,
  input  logic                      phv_valid_in,
  output logic                      ready_out,
  input  logic                      cfg_wr_en,
  input  logic                      cfg_wr_clr,
  input  logic [IDX_W-1:0]          cfg_wr_addr,
  input  logic [KEY_OFF-1:0]        cfg_wr_offset,
  input  logic [KEY_LEN-1:0]        cfg_wr_mask,
  output logic [PHV_LEN-1:0]        phv_out,
  output logic                      phv_valid_out,
  output logic                      key_offset_valid,
  output logic [KEY_OFF-1:0]        key_offset_w,
  output logic [KEY_LEN-1:0]        key_mask_w,
  input  logic                      ready_in,
  output logic [31:0]               pkt_cnt,
  output logic [31:0]               miss_cnt
);

  state_e             state_r, state_nx_s;
  logic               accept_s, load_key_s, issue_done_s;
  logic               valid_r, miss_r;
  logic               tbl_valid_s;
  logic [KEY_OFF-1:0] tbl_offset_s;
  logic [KEY_LEN-1:0] tbl_mask_s;
  logic               unused_vlan_s;

  assign unused_vlan_s = ^vlan_id_in[C_VLANID_WIDTH-1:IDX_W];

  // The table is read on the accept edge so its data is ready during LOOKUP.
  key_cfg_table #(.KEY_OFF(KEY_OFF), .KEY_LEN(KEY_LEN), .IDX_W(IDX_W)) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (cfg_wr_en),
    .wr_clr    (cfg_wr_clr),
    .wr_addr   (cfg_wr_addr),
    .wr_offset (cfg_wr_offset),
    .wr_mask   (cfg_wr_mask),
    .rd_en     (accept_s),
    .rd_addr   (vlan_id_in[IDX_W-1:0]),
    .rd_valid  (tbl_valid_s),
    .rd_offset (tbl_offset_s),
    .rd_mask   (tbl_mask_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state and per-state strobes.
  always_comb begin
    state_nx_s   = state_r;
    accept_s     = 1'b0;
    load_key_s   = 1'b0;
    issue_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (phv_valid_in) begin
          accept_s   = 1'b1;
          state_nx_s = ST_LOOKUP;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        load_key_s = 1'b1;
        state_nx_s = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (ready_in) begin
          issue_done_s = 1'b1;
          state_nx_s   = ST_GAP;
        end else begin
          state_nx_s = ST_ISSUE;
        end
      end
      ST_GAP:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  assign ready_out        = rst_n & (state_r == ST_IDLE);
  assign phv_valid_out    = valid_r;
  assign key_offset_valid = valid_r;

  // Output registers and counters; only loaded on their strobes so ISSUE stalls hold them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phv_out      <= '0;
      key_offset_w <= '0;
      key_mask_w   <= '0;
      valid_r      <= 1'b0;
      miss_r       <= 1'b0;
      pkt_cnt      <= 32'd0;
      miss_cnt     <= 32'd0;
    end else begin
      if (accept_s) begin
        phv_out <= phv_in;
      end
      if (load_key_s) begin
        valid_r <= 1'b1;
        miss_r  <= ~tbl_valid_s;
        if (tbl_valid_s) begin
          key_offset_w <= tbl_offset_s;
          key_mask_w   <= tbl_mask_s;
        end else begin
          key_offset_w <= {KEY_OFF{MISS_OFFSET_BIT}};
          key_mask_w   <= {KEY_LEN{MISS_MASK_BIT}};
        end
      end else if (issue_done_s) begin
        valid_r <= 1'b0;
      end
      if (issue_done_s) begin
        pkt_cnt <= pkt_cnt + 32'd1;
        if (miss_r) begin
          miss_cnt <= miss_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: doc/key_extract_sched.md
# key_extract_sched

Schedules PHVs into the stage's key extractor and configures it per packet. Holds a small per-VLAN table of key-offset and key-mask words, written over a configuration port. Looks up the entry for each incoming PHV and presents the PHV together with its offset and mask to the extractor. Paces issue so the extractor's two-cycle capture/extract sequence is never overrun.

## Interface
Parameters:
- PHV_LEN, 48*64+32*64+16*64+256: PHV width.
- KEY_LEN, 48*32+32*32+16*32+1: key and mask width.
- KEY_OFF, 32*6*3+20: key-offset word width.
- C_VLANID_WIDTH, 12: VLAN id width.
- IDX_W, 4: table index width; depth is 2**IDX_W.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- phv_in, in, PHV_LEN: upstream PHV.
- vlan_id_in, in, C_VLANID_WIDTH: VLAN id of phv_in.
- phv_valid_in, in, 1: upstream valid.
- ready_out, out, 1: upstream ready.
- cfg_wr_en, in, 1: table write strobe.
- cfg_wr_clr, in, 1: with cfg_wr_en, invalidate the entry instead of loading it.
- cfg_wr_addr, in, IDX_W: table entry.
- cfg_wr_offset, in, KEY_OFF: offset word to load.
- cfg_wr_mask, in, KEY_LEN: mask word to load.
- phv_out, out, PHV_LEN: PHV sent to the extractor.
- phv_valid_out, out, 1: PHV valid to the extractor.
- key_offset_valid, out, 1: offset/mask valid; identical to phv_valid_out.
- key_offset_w, out, KEY_OFF: offset for phv_out.
- key_mask_w, out, KEY_LEN: mask for phv_out.
- ready_in, in, 1: extractor ready.
- pkt_cnt, out, 32: PHVs issued; wraps.
- miss_cnt, out, 32: PHVs issued with an invalid entry; wraps.

## Operation
- Table: 2**IDX_W entries, each holding {valid, offset, mask}. Reset clears all valid bits; data contents are don't-care.
- Write with cfg_wr_en=1 and cfg_wr_clr=0: entry becomes {1, cfg_wr_offset, cfg_wr_mask}.
- Write with cfg_wr_en=1 and cfg_wr_clr=1: valid bit cleared; data unchanged.
- Writes are accepted every cycle, in any state.
- Index is vlan_id_in[IDX_W-1:0]; upper VLAN bits are ignored.
- State machine (one-hot), IDLE → LOOKUP → ISSUE → GAP → IDLE:
  - IDLE: ready_out=1. On phv_valid_in, capture phv_in and the index, then go to LOOKUP.
  - LOOKUP: read the indexed entry.
    - Hit: register offset and mask.
    - Miss: register offset=0 and mask=all-ones, so the masked key is 0 except bit 0.
    - Go to ISSUE.
  - ISSUE: phv_valid_out=key_offset_valid=1. Go to GAP on the first clock edge where ready_in=1. pkt_cnt increments at that edge; miss_cnt also increments if the entry was a miss.
  - GAP: valids low for one cycle, covering the extractor's second cycle. Then go to IDLE.
- ready_out=0 in every state except IDLE.

## Timing
- Reset values, all outputs: 0, with state IDLE. ready_out is 0 while rst_n=0 and 1 from the first cycle after deassertion.
- Accept edge E0 → LOOKUP. Edge E1 → ISSUE. Outputs are valid from E1 to the edge where ready_in=1 is sampled (E2 with no stall). GAP follows, then IDLE at E3+.
- Minimum spacing is 4 cycles per PHV. Latency from accept to first valid is 2 cycles.
- All outputs are registered except ready_out, which is decoded from the state register.
- Outputs hold stable throughout an ISSUE stall.
- A write to the index being read in LOOKUP, in the same cycle, returns the old entry (read-before-write). A write during ISSUE does not change the issued offset/mask.
- Asserting rst_n low in any state returns to IDLE and drops valids immediately. An in-flight PHV is discarded and not counted.
- phv_valid_in is ignored outside IDLE. Upstream holds its data until ready_out is seen high.

## Structure
- Package key_extract_pkg holds the default widths, WIDTH_2B/4B/6B, the state encodings, and the miss defaults (offset 0, mask all-ones).
- Sub-module key_cfg_table:
  - one write port with clr;
  - one registered read port returning {valid, offset, mask};
  - asynchronous reset of the valid bits only.
- Top level is the state machine, the capture registers and the counters.

## Test plan
- Write entry 3 = {offset A, mask 0}, then send a PHV with vlan_id 0x013. Expect phv_out=phv_in, key_offset_w=A, key_mask_w=0, valid 2 cycles after accept, pkt_cnt=1, miss_cnt=0.
- Send a PHV with vlan_id 5 (never written). Expect key_offset_w=0, key_mask_w=all-ones, miss_cnt=1.
- Hold ready_in=0 for 5 cycles in ISSUE. Expect outputs held unchanged, ready_out=0, a single pkt_cnt increment after release, and GAP observed before the next accept.
- Hold phv_valid_in=1 for 12 cycles. Expect exactly 3 accepts, spaced 4 cycles apart, with valids never high on consecutive cycles across PHVs.
- In the LOOKUP cycle, write offset B to the same entry (old value A). Expect this PHV to issue with A and the next PHV with B. Then clear the entry; expect the following PHV to miss.
- Assert rst_n low during ISSUE. Expect all outputs 0 asynchronously, counters 0, all entries invalid afterwards.
